ex_alu_stage: RTL and testbench
===============================

Name: ex_alu_stage

Overview:
Execute stage of the RVX10 five-stage pipeline, directly downstream of the ALU decoder. Holds the ID/EX pipeline register (stall/flush aware), applies forwarding selection to both operands and the ALUSrc mux, and evaluates the 5-bit ALUControl op set, base RV32I plus RVX10. Outputs feed the EX/MEM register and the hazard unit.

Parameters:
XLEN, 32, datapath width; rotate amount uses low $clog2(XLEN) bits of operand B.

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-high reset
StallE  in  1  hold ID/EX contents
FlushE  in  1  load bubble into ID/EX
ValidD  in  1  instruction present in decode
RegWriteD  in  1  decode register-write enable
ALUSrcD  in  1  0: B = forwarded RD2, 1: B = immediate
ALUControlD  in  5  op code from ALU decoder
RD1D, RD2D  in  XLEN  register file read data
ImmExtD  in  XLEN  sign-extended immediate
Rs1D, Rs2D, RdD  in  5  register indices
ForwardAE, ForwardBE  in  2  00 register, 01 ResultW, 10 ALUResultM, 11 treated as 00
ALUResultM  in  XLEN  MEM-stage result for forwarding
ResultW  in  XLEN  WB-stage result for forwarding
ALUResultE  out  XLEN  execute result
WriteDataE  out  XLEN  forwarded RD2 (store data)
ZeroE  out  1  ALUResultE == 0
IllegalE  out  1  ValidE and ALUControlE unsupported
ValidE, RegWriteE  out  1  registered controls
Rs1E, Rs2E, RdE  out  5  registered indices for hazard unit

Behaviour:
- ID/EX register: posedge clk, async reset. Priority reset > FlushE > StallE > load.
- Reset and flush both load a bubble: all registered fields 0 (ValidE=0, RegWriteE=0, ALUControlE=00000, data/indices 0).
- FlushE with StallE in same cycle: flush wins.
- Stall: every field holds. Forwarded operands still recompute each cycle from the current ForwardAE/BE, ALUResultM and ResultW.
- Load: RegWriteE captures RegWriteD & ValidD & (RdD != 0), so x0 is never written.
- Latency: decode inputs appear on E outputs one cycle later. ALUResultE, WriteDataE, ZeroE and IllegalE are combinational from the registered state and the forwarding inputs.
- Operands: SrcA = fwd(RD1E, ForwardAE). WriteDataE = fwd(RD2E, ForwardBE). SrcB = ALUSrcE ? ImmExtE : WriteDataE.
- Op codes: 00000 add; 00001 sub; 00010 and; 00011 or; 00101 slt (signed, result 0/1).
- RVX10 op codes:
  - 01000 ANDN = A & ~B; 01001 ORN = A | ~B; 01010 XNOR = ~(A ^ B).
  - 01011 MIN, 01100 MAX (signed); 01101 MINU, 01110 MAXU (unsigned).
  - 01111 ROL, 10000 ROR by B[4:0]; shift 0 returns A.
  - 10001 ABS = |A|; ABS(0x80000000) = 0x80000000, wrap with no trap.
- All arithmetic is modulo 2^XLEN; no overflow flag.
- Unsupported code: ALUResultE = 0 and IllegalE = ValidE. For a bubble, IllegalE = 0.
- Reset mid-stall: bubble loads immediately (asynchronous) and stall is irrelevant until release.

Optional Feature:
RVX10_EXT_EN
- Defined: codes 01000–10001 implemented as above.
- Undefined: those codes are unsupported, giving result 0 and IllegalE asserted for a valid instruction. Base ops are unchanged. The rotate/min/max logic is not synthesised.

Decomposition:
- Shared package alu_pkg: enum alu_op_e (5-bit codes above, same values the decoder drives), enum fwd_sel_e (FWD_REG=00, FWD_W=01, FWD_M=10), XLEN default constant.
- One natural sub-module: alu_core, purely combinational (SrcA, SrcB, ALUControl in; result and illegal out). ex_alu_stage instantiates it alongside the register and muxes.

Test Plan:
- Reset asserted mid-cycle with ID/EX loaded -> immediately ValidE=0, RegWriteE=0, ALUResultE=0, IllegalE=0.
- Load sub, RD1D=5, RD2D=7 -> next cycle ALUResultE=0xFFFFFFFE, ZeroE=0. Then load add, 3+(-3) -> ZeroE=1.
- StallE held 2 cycles after loading ROL A=0x80000001, B=4 -> ALUResultE=0x00000018 throughout.
  - ForwardAE=10 with ALUResultM=0x10 during the stall -> result 0x00000100.
- FlushE and StallE together while loading RdD=3, RegWriteD=1 -> bubble: RegWriteE=0, ValidE=0. Load RdD=0, RegWriteD=1 -> RegWriteE=0.
- MIN/MINU on A=0xFFFFFFFF, B=1 -> 0xFFFFFFFF / 0x00000001. ABS A=0x80000000 -> 0x80000000. ORN A=0, B=0 -> 0xFFFFFFFF.
- Code 00100 valid -> result 0, IllegalE=1.
  - Build without RVX10_EXT_EN: code 01010 -> IllegalE=1.
  - Build with RVX10_EXT_EN: code 01010 -> IllegalE=0 and XNOR result.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the RVX10 execute stage.
//   XLEN_DEFAULT - default datapath width
//   alu_op_e     - 5-bit ALUControl codes, identical to what the ALU decoder drives
//   fwd_sel_e    - forwarding mux selects driven by the hazard unit
package alu_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_AND  = 5'b00010,
    OP_OR   = 5'b00011,
    OP_SLT  = 5'b00101,
    OP_ANDN = 5'b01000,
    OP_ORN  = 5'b01001,
    OP_XNOR = 5'b01010,
    OP_MIN  = 5'b01011,
    OP_MAX  = 5'b01100,
    OP_MINU = 5'b01101,
    OP_MAXU = 5'b01110,
    OP_ROL  = 5'b01111,
    OP_ROR  = 5'b10000,
    OP_ABS  = 5'b10001
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU for the RVX10 execute stage.
// Ports:
//   src_a, src_b  in  XLEN  operands
//   alu_control   in  5     op code (alu_op_e values)
//   result        out XLEN  op result, 0 for unsupported codes
//   illegal       out 1     op code unsupported in this build
// Build option: define RVX10_EXT_EN to implement the RVX10 ops (01000-10001);
// otherwise those codes report illegal and their logic is not built.
import alu_pkg::*;

module alu_core #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

`ifdef RVX10_EXT_EN
  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0]  shamt;
  logic [SHW-1:0]  rol_amt;
  logic [XLEN-1:0] ror_res;
  logic [XLEN-1:0] rol_res;
  logic            lt_s;
  logic            lt_u;

  // Rotates come from the low half of {A,A} shifted right; a left rotate by n
  // is a right rotate by (-n mod XLEN), so shift 0 yields A in both cases.
  always_comb begin
    shamt   = src_b[SHW-1:0];
    rol_amt = -shamt;
    ror_res = XLEN'({src_a, src_a} >> shamt);
    rol_res = XLEN'({src_a, src_a} >> rol_amt);
    lt_s    = $signed(src_a) < $signed(src_b);
    lt_u    = src_a < src_b;
  end
`endif

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_control)
      OP_ADD:  result = src_a + src_b;
      OP_SUB:  result = src_a - src_b;
      OP_AND:  result = src_a & src_b;
      OP_OR:   result = src_a | src_b;
      OP_SLT:  result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
`ifdef RVX10_EXT_EN
      OP_ANDN: result = src_a & ~src_b;
      OP_ORN:  result = src_a | ~src_b;
      OP_XNOR: result = ~(src_a ^ src_b);
      OP_MIN:  result = lt_s ? src_a : src_b;
      OP_MAX:  result = lt_s ? src_b : src_a;
      OP_MINU: result = lt_u ? src_a : src_b;
      OP_MAXU: result = lt_u ? src_b : src_a;
      OP_ROL:  result = rol_res;
      OP_ROR:  result = ror_res;
      // Most negative value negates to itself (wraps, no trap).
      OP_ABS:  result = src_a[XLEN-1] ? -src_a : src_a;
`endif
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// ex_alu_stage: execute stage of the RVX10 pipeline.
// Holds the ID/EX register (reset > FlushE > StallE > load), selects forwarded
// operands, applies the ALUSrc mux and evaluates the ALU.
// Ports:
//   clk, reset              clock, async active-high reset
//   StallE, FlushE          hold / bubble the ID/EX register
//   ValidD .. RdD           decode-stage fields captured into ID/EX
//   ForwardAE, ForwardBE    00 reg, 01 ResultW, 10 ALUResultM, 11 reg
//   ALUResultM, ResultW     forwarding sources
//   ALUResultE, WriteDataE  execute result and store data (combinational)
//   ZeroE, IllegalE         result-is-zero, valid op unsupported
//   ValidE, RegWriteE       registered controls
//   Rs1E, Rs2E, RdE         registered indices for the hazard unit
// Build option: RVX10_EXT_EN enables the RVX10 op set in alu_core.
import alu_pkg::*;

module ex_alu_stage #(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            ALUSrcD,
  input  logic [4:0]      ALUControlD,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ResultW,
  output logic [XLEN-1:0] ALUResultE,
  output logic [XLEN-1:0] WriteDataE,
  output logic            ZeroE,
  output logic            IllegalE,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE
);

  logic            alusrc_e;
  logic [4:0]      alu_control_e;
  logic [XLEN-1:0] rd1_e;
  logic [XLEN-1:0] rd2_e;
  logic [XLEN-1:0] imm_e;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] core_result;
  logic            core_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ValidE        <= 1'b0;
      RegWriteE     <= 1'b0;
      alusrc_e      <= 1'b0;
      alu_control_e <= '0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      imm_e         <= '0;
      Rs1E          <= '0;
      Rs2E          <= '0;
      RdE           <= '0;
    end else if (FlushE) begin
      ValidE        <= 1'b0;
      RegWriteE     <= 1'b0;
      alusrc_e      <= 1'b0;
      alu_control_e <= '0;
      rd1_e         <= '0;
      rd2_e         <= '0;
      imm_e         <= '0;
      Rs1E          <= '0;
      Rs2E          <= '0;
      RdE           <= '0;
    end else if (!StallE) begin
      ValidE        <= ValidD;
      // x0 is never a write target, and a bubble never writes.
      RegWriteE     <= RegWriteD & ValidD & (RdD != 5'd0);
      alusrc_e      <= ALUSrcD;
      alu_control_e <= ALUControlD;
      rd1_e         <= RD1D;
      rd2_e         <= RD2D;
      imm_e         <= ImmExtD;
      Rs1E          <= Rs1D;
      Rs2E          <= Rs2D;
      RdE           <= RdD;
    end
  end

  // Forwarding stays live during a stall: the held register values are
  // re-muxed every cycle against the current forwarding selects.
  always_comb begin
    case (ForwardAE)
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = ALUResultM;
      default: src_a = rd1_e;
    endcase
    case (ForwardBE)
      FWD_W:   WriteDataE = ResultW;
      FWD_M:   WriteDataE = ALUResultM;
      default: WriteDataE = rd2_e;
    endcase
    src_b = alusrc_e ? imm_e : WriteDataE;
  end

  alu_core #(
    .XLEN(XLEN)
  ) u_alu_core (
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_control(alu_control_e),
    .result     (core_result),
    .illegal    (core_illegal)
  );

  always_comb begin
    ALUResultE = core_result;
    ZeroE      = (core_result == '0);
    IllegalE   = ValidE & core_illegal;
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
module tb_ex_alu_stage;

`ifdef RVX10_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        StallE, FlushE, ValidD, RegWriteD, ALUSrcD;
  logic [4:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ALUResultM, ResultW;
  logic [31:0] ALUResultE, WriteDataE;
  logic        ZeroE, IllegalE, ValidE, RegWriteE;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int checks = 0;
  int errors = 0;

  // Reference view of the ID/EX contents.
  logic        m_valid, m_rw, m_alusrc;
  logic [4:0]  m_op, m_rs1, m_rs2, m_rd;
  logic [31:0] m_rd1, m_rd2, m_imm;

  // Expected outputs derived from the reference view.
  logic [31:0] e_res, e_wd;
  logic        e_zero, e_ill;

  ex_alu_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD),
    .ALUControlD(ALUControlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .ZeroE(ZeroE),
    .IllegalE(IllegalE), .ValidE(ValidE), .RegWriteE(RegWriteE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ops written straight from their definitions.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output logic bad);
    logic [31:0] r;
    int sa, sb;
    r = 32'd0;
    bad = 1'b0;
    sa = a;
    sb = b;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a & b;
      5'd3:  r = a | b;
      5'd5:  r = (sa < sb) ? 32'd1 : 32'd0;
      default: bad = 1'b1;
    endcase
    if (bad && EXT) begin
      bad = 1'b0;
      case (op)
        5'd8:  r = a & ~b;
        5'd9:  r = a | ~b;
        5'd10: r = ~(a ^ b);
        5'd11: r = (sa < sb) ? a : b;
        5'd12: r = (sa > sb) ? a : b;
        5'd13: r = (a < b) ? a : b;
        5'd14: r = (a > b) ? a : b;
        5'd15: begin
          r = a;
          for (int i = 0; i < int'(b % 32); i++) r = {r[30:0], r[31]};
        end
        5'd16: begin
          r = a;
          for (int i = 0; i < int'(b % 32); i++) r = {r[0], r[31:1]};
        end
        5'd17: r = (sa < 0) ? 32'(0 - sa) : a;
        default: bad = 1'b1;
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] fwd(input logic [31:0] regv, input logic [1:0] sel);
    if (sel == 2'b01) return ResultW;
    if (sel == 2'b10) return ALUResultM;
    return regv;
  endfunction

  task automatic calc_exp();
    logic [31:0] a, b;
    logic bad;
    a      = fwd(m_rd1, ForwardAE);
    e_wd   = fwd(m_rd2, ForwardBE);
    b      = m_alusrc ? m_imm : e_wd;
    e_res  = ref_alu(m_op, a, b, bad);
    if (bad) e_res = 32'd0;
    e_ill  = m_valid & bad;
    e_zero = (e_res == 32'd0);
  endtask

  task automatic m_clear();
    m_valid = 0; m_rw = 0; m_alusrc = 0; m_op = 0;
    m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
  endtask

  task automatic drive(input logic v, input logic rw, input logic src, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    ValidD = v; RegWriteD = rw; ALUSrcD = src; ALUControlD = op;
    RD1D = a; RD2D = b; ImmExtD = imm; Rs1D = rs1; Rs2D = rs2; RdD = rd;
  endtask

  // Advance one clock; the reference register follows flush > stall > load.
  task automatic tick();
    if (FlushE) m_clear();
    else if (!StallE) begin
      m_valid = ValidD; m_rw = RegWriteD & ValidD & (RdD != 5'd0);
      m_alusrc = ALUSrcD; m_op = ALUControlD; m_rd1 = RD1D; m_rd2 = RD2D;
      m_imm = ImmExtD; m_rs1 = Rs1D; m_rs2 = Rs2D; m_rd = RdD;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 5'd0, 32'd10, 32'd20, 32'd0, 5'd1, 5'd2, 5'd5);
    tick();
    checks++;
    if (ALUResultE !== 32'd30 || ValidE !== 1'b1 || RegWriteE !== 1'b1 || RdE !== 5'd5) begin
      errors++;
      $display("FAIL reset_preload got res=%h v=%b rw=%b rd=%0d exp res=0000001e v=1 rw=1 rd=5",
               ALUResultE, ValidE, RegWriteE, RdE);
    end
    StallE = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    m_clear();
    checks++;
    if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || ALUResultE !== 32'd0 || IllegalE !== 1'b0 ||
        ZeroE !== 1'b1 || {Rs1E, Rs2E, RdE} !== 15'd0) begin
      errors++;
      $display("FAIL reset_async got v=%b rw=%b res=%h ill=%b z=%b idx=%h exp v=0 rw=0 res=0 ill=0 z=1 idx=0",
               ValidE, RegWriteE, ALUResultE, IllegalE, ZeroE, {Rs1E, Rs2E, RdE});
    end
    @(posedge clk);
    #1;
    checks++;
    if (ValidE !== 1'b0 || ALUResultE !== 32'd0) begin
      errors++;
      $display("FAIL reset_hold got v=%b res=%h exp v=0 res=0", ValidE, ALUResultE);
    end
    reset = 1'b0;
    StallE = 1'b0;
  endtask

  task automatic test_add_sub();
    drive(1, 1, 0, 5'd1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if (ALUResultE !== 32'hFFFF_FFFE || ZeroE !== 1'b0 || WriteDataE !== 32'd7) begin
      errors++;
      $display("FAIL sub got res=%h z=%b wd=%h exp res=fffffffe z=0 wd=00000007",
               ALUResultE, ZeroE, WriteDataE);
    end
    drive(1, 1, 1, 5'd0, 32'd3, 32'd9, 32'hFFFF_FFFD, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if (ALUResultE !== 32'd0 || ZeroE !== 1'b1) begin
      errors++;
      $display("FAIL add_zero got res=%h z=%b exp res=0 z=1", ALUResultE, ZeroE);
    end
    drive(1, 1, 0, 5'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if (ALUResultE !== 32'd1) begin
      errors++;
      $display("FAIL slt got %h exp 00000001", ALUResultE);
    end
  endtask

  task automatic test_stall_fwd();
    logic [31:0] exp_rol, exp_fwd;
    exp_rol = EXT ? 32'h0000_0018 : 32'd0;
    exp_fwd = EXT ? 32'h0000_0100 : 32'd0;
    drive(1, 1, 1, 5'd15, 32'h8000_0001, 32'd0, 32'd4, 5'd6, 5'd7, 5'd8);
    tick();
    StallE = 1'b1;
    drive(1, 1, 0, 5'd0, 32'd1, 32'd2, 32'd3, 5'd9, 5'd10, 5'd11);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ALUResultE !== exp_rol || IllegalE !== !EXT || RdE !== 5'd8 || Rs1E !== 5'd6) begin
        errors++;
        $display("FAIL stall_hold[%0d] got res=%h ill=%b rd=%0d rs1=%0d exp res=%h ill=%b rd=8 rs1=6",
                 c, ALUResultE, IllegalE, RdE, Rs1E, exp_rol, !EXT);
      end
    end
    ForwardAE = 2'b10;
    ALUResultM = 32'h10;
    #1;
    checks++;
    if (ALUResultE !== exp_fwd) begin
      errors++;
      $display("FAIL stall_fwd_m got %h exp %h", ALUResultE, exp_fwd);
    end
    ForwardAE = 2'b11;
    #1;
    checks++;
    if (ALUResultE !== exp_rol) begin
      errors++;
      $display("FAIL fwd_11_reg got %h exp %h", ALUResultE, exp_rol);
    end
    ForwardAE = 2'b00;
    StallE = 1'b0;
    // B-side forwarding from WB feeds store data and the ALU.
    drive(1, 1, 0, 5'd0, 32'd100, 32'd1, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    ForwardBE = 2'b01;
    ResultW = 32'd23;
    #1;
    checks++;
    if (WriteDataE !== 32'd23 || ALUResultE !== 32'd123) begin
      errors++;
      $display("FAIL fwd_b_w got wd=%h res=%h exp wd=00000017 res=0000007b", WriteDataE, ALUResultE);
    end
    ForwardBE = 2'b00;
  endtask

  task automatic test_flush();
    FlushE = 1'b1;
    StallE = 1'b1;
    drive(1, 1, 0, 5'd4, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if (RegWriteE !== 1'b0 || ValidE !== 1'b0 || RdE !== 5'd0 || IllegalE !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got rw=%b v=%b rd=%0d ill=%b exp rw=0 v=0 rd=0 ill=0",
               RegWriteE, ValidE, RdE, IllegalE);
    end
    FlushE = 1'b0;
    StallE = 1'b0;
    drive(1, 1, 0, 5'd0, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd0);
    tick();
    checks++;
    if (RegWriteE !== 1'b0 || ValidE !== 1'b1) begin
      errors++;
      $display("FAIL x0_write got rw=%b v=%b exp rw=0 v=1", RegWriteE, ValidE);
    end
    drive(0, 1, 0, 5'd0, 32'd1, 32'd2, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if (RegWriteE !== 1'b0 || ValidE !== 1'b0 || RdE !== 5'd3) begin
      errors++;
      $display("FAIL invalid_write got rw=%b v=%b rd=%0d exp rw=0 v=0 rd=3", RegWriteE, ValidE, RdE);
    end
  endtask

  task automatic test_rvx10();
    logic [4:0]  ops [11];
    logic [31:0] as  [11];
    logic [31:0] bs  [11];
    logic [31:0] rs  [11];
    logic [31:0] exp_r;
    ops = '{5'd11, 5'd13, 5'd12, 5'd14, 5'd17, 5'd17, 5'd9, 5'd10, 5'd8, 5'd16, 5'd15};
    as  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
            32'hFFFF_FFFB, 32'h0, 32'h0F0F_0F0F, 32'hFF00_FF00, 32'h8000_0001, 32'h1234_5678};
    bs  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd0, 32'h0, 32'h00FF_00FF, 32'h0F0F_0F0F,
            32'd4, 32'h20};
    rs  = '{32'hFFFF_FFFF, 32'h1, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h5, 32'hFFFF_FFFF,
            32'hF00F_F00F, 32'hF000_F000, 32'h1800_0000, 32'h1234_5678};
    for (int i = 0; i < 11; i++) begin
      drive(1, 1, 0, ops[i], as[i], bs[i], 32'd0, 5'd1, 5'd2, 5'd3);
      tick();
      exp_r = EXT ? rs[i] : 32'd0;
      checks++;
      if (ALUResultE !== exp_r || IllegalE !== !EXT) begin
        errors++;
        $display("FAIL rvx10[%0d] op=%b got res=%h ill=%b exp res=%h ill=%b",
                 i, ops[i], ALUResultE, IllegalE, exp_r, !EXT);
      end
    end
    drive(1, 1, 0, 5'd4, 32'd9, 32'd9, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if (ALUResultE !== 32'd0 || IllegalE !== 1'b1) begin
      errors++;
      $display("FAIL illegal_00100 got res=%h ill=%b exp res=0 ill=1", ALUResultE, IllegalE);
    end
    drive(1, 1, 0, 5'd18, 32'd9, 32'd9, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if (ALUResultE !== 32'd0 || IllegalE !== 1'b1) begin
      errors++;
      $display("FAIL illegal_10010 got res=%h ill=%b exp res=0 ill=1", ALUResultE, IllegalE);
    end
    drive(0, 0, 0, 5'd4, 32'd9, 32'd9, 32'd0, 5'd1, 5'd2, 5'd3);
    tick();
    checks++;
    if (IllegalE !== 1'b0 || ALUResultE !== 32'd0) begin
      errors++;
      $display("FAIL illegal_bubble got res=%h ill=%b exp res=0 ill=0", ALUResultE, IllegalE);
    end
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int n = 0; n < 400; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 17));
      drive(1'($urandom), 1'($urandom), 1'($urandom), op,
            ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom,
            ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, $urandom,
            5'($urandom), 5'($urandom), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom));
      StallE = ($urandom_range(0, 3) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      tick();
      for (int k = 0; k < 2; k++) begin
        ForwardAE = 2'($urandom);
        ForwardBE = 2'($urandom);
        ALUResultM = $urandom;
        ResultW = $urandom;
        #1;
        calc_exp();
        checks++;
        if (ALUResultE !== e_res || WriteDataE !== e_wd || ZeroE !== e_zero || IllegalE !== e_ill) begin
          errors++;
          $display("FAIL rand_data[%0d.%0d] op=%b got res=%h wd=%h z=%b ill=%b exp res=%h wd=%h z=%b ill=%b",
                   n, k, m_op, ALUResultE, WriteDataE, ZeroE, IllegalE, e_res, e_wd, e_zero, e_ill);
        end
      end
      checks++;
      if (ValidE !== m_valid || RegWriteE !== m_rw || {Rs1E, Rs2E, RdE} !== {m_rs1, m_rs2, m_rd}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d] got v=%b rw=%b idx=%h exp v=%b rw=%b idx=%h",
                 n, ValidE, RegWriteE, {Rs1E, Rs2E, RdE}, m_valid, m_rw, {m_rs1, m_rs2, m_rd});
      end
    end
    StallE = 1'b0;
    FlushE = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
  endtask

  initial begin
    reset = 1'b1;
    StallE = 1'b0;
    FlushE = 1'b0;
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    ALUResultM = 32'd0;
    ResultW = 32'd0;
    drive(0, 0, 0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_add_sub();
    test_stall_fwd();
    test_flush();
    test_rvx10();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
